// File: rtl/punc_controller.sv
// PUnC LC3 control FSM: sequences fetch, decode and execute and drives every datapath strobe, select, address and immediate.
// Latency (FETCH_WAIT=1): ALU/BR/JMP/JSR/LEA 4 cycles, LD/LDR/ST/STR/STI 5 cycles, LDI 6 cycles, counted from FETCH entry back to FETCH.
// Backpressure: none; the datapath and memory are assumed to complete every access in the cycle the FSM allots to it.
module punc_controller #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         FETCH_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic        PC_ld_register,
    output logic        PC_ld_offset,
    output logic        PC_clr,
    output logic        PC_inc,
    output logic        IR_ld,
    output logic [2:0]  readCtrAddr,
    output logic [15:0] ctrAddr,
    output logic        immSelect,
    output logic [15:0] immValue,
    output logic [2:0]  regFile_r_addr_0,
    output logic [2:0]  regFile_r_addr_1,
    output logic [2:0]  regFile_w_addr_0,
    output logic        regFile_w_en,
    output logic [2:0]  selectALU,
    output logic        modCond,
    output logic [2:0]  W_dataSelect_RF,
    output logic [15:0] LOAD_offset,
    output logic        memWriteEn,
    output logic [1:0]  W_addrSelect_M,
    output logic [15:0] WRITE_offset,
    output logic        halted,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JSR = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_LEA = 4'hE;

    // Read-address mux codes
    localparam logic [2:0] RD_PC      = 3'd0;
    localparam logic [2:0] RD_PC_OFF  = 3'd2;
    localparam logic [2:0] RD_MEMDAT  = 3'd3;
    localparam logic [2:0] RD_RF0_OFF = 3'd4;
    localparam logic [2:0] RD_HOLD    = 3'd5;

    // ALU op codes
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_AND   = 3'd1;
    localparam logic [2:0] ALU_NOT   = 3'd2;
    localparam logic [2:0] ALU_PASSA = 3'd4;

    // Register-file write data codes
    localparam logic [2:0] WD_MEM    = 3'd1;
    localparam logic [2:0] WD_PC     = 3'd2;
    localparam logic [2:0] WD_PC_OFF = 3'd3;

    // Memory write address codes
    localparam logic [1:0] WA_PC_OFF  = 2'd0;
    localparam logic [1:0] WA_RF0_OFF = 2'd1;
    localparam logic [1:0] WA_MEMDAT  = 2'd2;

    localparam logic [1:0] FW = FETCH_WAIT[1:0];

    state_t     state;
    state_t     state_nxt;
    logic [1:0] fetch_cnt;
    logic [1:0] fetch_cnt_nxt;
    logic       ldi_phase;
    logic       ldi_phase_nxt;

    // Instruction fields
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        br_taken;
    logic [15:0] sext5;
    logic [15:0] sext6;
    logic [15:0] sext9;
    logic [15:0] sext11;

    assign opcode   = ir[15:12];
    assign dr       = ir[11:9];
    assign sr1      = ir[8:6];
    assign sr2      = ir[2:0];
    assign br_taken = |(ir[11:9] & {N, Z, P});
    assign sext5    = {{11{ir[4]}}, ir[4:0]};
    assign sext6    = {{10{ir[5]}}, ir[5:0]};
    assign sext9    = {{7{ir[8]}}, ir[8:0]};
    assign sext11   = {{5{ir[10]}}, ir[10:0]};

    assign ctrAddr   = 16'h0000;
    assign state_dbg = state;

    // State register, fetch-wait counter and LDI phase; reset also abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            fetch_cnt <= 2'd0;
            ldi_phase <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_cnt <= fetch_cnt_nxt;
            ldi_phase <= ldi_phase_nxt;
        end
    end

    // Next-state and all datapath controls, decoded from state and ir
    always_comb begin
        state_nxt        = state;
        fetch_cnt_nxt    = 2'd0;
        ldi_phase_nxt    = 1'b0;
        PC_ld_register   = 1'b0;
        PC_ld_offset     = 1'b0;
        PC_clr           = 1'b0;
        PC_inc           = 1'b0;
        IR_ld            = 1'b0;
        readCtrAddr      = RD_PC;
        immSelect        = 1'b0;
        immValue         = 16'h0000;
        regFile_r_addr_0 = 3'd0;
        regFile_r_addr_1 = 3'd0;
        regFile_w_addr_0 = 3'd0;
        regFile_w_en     = 1'b0;
        selectALU        = ALU_ADD;
        modCond          = 1'b0;
        W_dataSelect_RF  = 3'd0;
        LOAD_offset      = 16'h0000;
        memWriteEn       = 1'b0;
        W_addrSelect_M   = WA_PC_OFF;
        WRITE_offset     = 16'h0000;
        halted           = 1'b0;

        // Field-derived addresses and offsets follow ir everywhere except INIT,
        // so the datapath sees them a cycle ahead of the strobe that uses them.
        if (state != S_INIT) begin
            immValue         = sext5;
            regFile_r_addr_0 = sr1;
            regFile_r_addr_1 = sr2;
            regFile_w_addr_0 = dr;
            LOAD_offset      = (opcode == OP_LDR) ? sext6 : sext9;
            if (opcode == OP_JSR)
                WRITE_offset = sext11;
            else if (opcode == OP_STR)
                WRITE_offset = sext6;
            else
                WRITE_offset = sext9;
        end

        case (state)
            S_INIT: begin
                PC_clr    = 1'b1;
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                readCtrAddr = RD_PC;
                if (fetch_cnt == FW) begin
                    state_nxt = S_DECODE;
                end else begin
                    fetch_cnt_nxt = fetch_cnt + 2'd1;
                end
            end

            S_DECODE: begin
                // pc increments here, so every pc-relative offset in EXEC is from pc+1
                IR_ld     = 1'b1;
                PC_inc    = 1'b1;
                state_nxt = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_ADD, OP_AND: begin
                        selectALU    = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
                        immSelect    = ir[5];
                        regFile_w_en = 1'b1;
                        modCond      = 1'b1;
                    end
                    OP_NOT: begin
                        selectALU    = ALU_NOT;
                        regFile_w_en = 1'b1;
                        modCond      = 1'b1;
                    end
                    OP_BR: begin
                        PC_ld_offset = br_taken;
                    end
                    OP_JMP: begin
                        PC_ld_register = 1'b1;
                    end
                    OP_JSR: begin
                        // R7 captures pc (already pc+1) in the same cycle pc is redirected
                        W_dataSelect_RF  = WD_PC;
                        regFile_w_addr_0 = 3'd7;
                        regFile_w_en     = 1'b1;
                        PC_ld_offset     = ir[11];
                        PC_ld_register   = ~ir[11];
                    end
                    OP_LD: begin
                        readCtrAddr = RD_PC_OFF;
                        state_nxt   = S_EXEC2;
                    end
                    OP_LDR: begin
                        readCtrAddr = RD_RF0_OFF;
                        state_nxt   = S_EXEC2;
                    end
                    OP_LDI: begin
                        readCtrAddr = RD_PC_OFF;
                        state_nxt   = S_EXEC2;
                    end
                    OP_LEA: begin
                        W_dataSelect_RF = WD_PC_OFF;
                        regFile_w_en    = 1'b1;
                        modCond         = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        // Store data is read through the ALU this cycle; the write follows
                        regFile_r_addr_0 = dr;
                        selectALU        = ALU_PASSA;
                        state_nxt        = S_EXEC2;
                    end
                    OP_STI: begin
                        // Fetch the pointer while presenting the store data
                        readCtrAddr      = RD_PC_OFF;
                        regFile_r_addr_0 = dr;
                        selectALU        = ALU_PASSA;
                        state_nxt        = S_EXEC2;
                    end
                    default: begin
                        state_nxt = S_FETCH;
                    end
                endcase
            end

            S_EXEC2: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LD, OP_LDR: begin
                        readCtrAddr     = RD_HOLD;
                        W_dataSelect_RF = WD_MEM;
                        regFile_w_en    = 1'b1;
                        modCond         = 1'b1;
                    end
                    OP_LDI: begin
                        if (!ldi_phase) begin
                            // First pass: dereference the pointer just read
                            readCtrAddr   = RD_MEMDAT;
                            ldi_phase_nxt = 1'b1;
                            state_nxt     = S_EXEC2;
                        end else begin
                            readCtrAddr     = RD_HOLD;
                            W_dataSelect_RF = WD_MEM;
                            regFile_w_en    = 1'b1;
                            modCond         = 1'b1;
                        end
                    end
                    OP_ST: begin
                        regFile_r_addr_0 = dr;
                        selectALU        = ALU_PASSA;
                        W_addrSelect_M   = WA_PC_OFF;
                        memWriteEn       = 1'b1;
                    end
                    OP_STR: begin
                        // Port 0 switches to BaseR for the address; data was captured in EXEC
                        regFile_r_addr_0 = sr1;
                        selectALU        = ALU_PASSA;
                        W_addrSelect_M   = WA_RF0_OFF;
                        memWriteEn       = 1'b1;
                    end
                    OP_STI: begin
                        readCtrAddr      = RD_HOLD;
                        regFile_r_addr_0 = dr;
                        selectALU        = ALU_PASSA;
                        W_addrSelect_M   = WA_MEMDAT;
                        memWriteEn       = 1'b1;
                    end
                    default: begin
                        state_nxt = S_FETCH;
                    end
                endcase
            end

            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

endmodule
